// File: rtl/fraction_accumulator_if.sv
// ---------------------------------------------------------------------------
// fraction_accumulator_if
// Groups the multiplier-side inputs, the batch-result handshake and the
// status flags of fraction_accumulator.
//
// Handshake: the result side follows valid/ready semantics. Sum is
// presented with Valid high and stays stable until the cycle in which Ready
// is also high. That cycle is the transfer. Ready may be asserted at any
// time, and it has no effect while Valid is low.
//
// Signals (directions seen from the slave, i.e. the accumulator):
//   Done      in   multiplier completion level; each rising edge is one product
//   Product   in   Q1.6 two's-complement product, valid while Done is high
//   Count     in   products per batch, 0 encodes 8
//   Clr       in   synchronous batch abort / clear
//   Ready     in   downstream accepts Sum
//   Sum       out  Q4.4 rounded batch total
//   Valid     out  Sum holds a completed batch
//   Busy      out  accumulator is not idle
//   Ovr       out  sticky: a product arrived while a result was pending
//   state_dbg out  current FSM state (0 idle, 1 accumulating, 2 full)
// ---------------------------------------------------------------------------
interface fraction_accumulator_if;
  logic       Done;
  logic [6:0] Product;
  logic [2:0] Count;
  logic       Clr;
  logic       Ready;
  logic [7:0] Sum;
  logic       Valid;
  logic       Busy;
  logic       Ovr;
  logic [1:0] state_dbg;

  modport master (
    output Done, Product, Count, Clr, Ready,
    input  Sum, Valid, Busy, Ovr, state_dbg
  );

  modport slave (
    input  Done, Product, Count, Clr, Ready,
    output Sum, Valid, Busy, Ovr, state_dbg
  );
endinterface

// File: rtl/fraction_accumulator.sv
// ---------------------------------------------------------------------------
// fraction_accumulator
// Collects a batch of Q1.6 products from a multiplier. The multiplier
// signals each product with a Done level, and the block captures one
// product per rising edge of Done. When the batch is complete, the block
// presents the sum, rounded to Q4.4, with a valid/ready handshake.
//
// Ports:
//   CLK   rising-edge clock
//   RSTn  asynchronous active-low reset
//   bus   fraction_accumulator_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module fraction_accumulator (
  input logic                   CLK,
  input logic                   RSTn,
  fraction_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              done_q;
  logic signed [9:0] acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        tgt_q, tgt_d;
  logic [7:0]        sum_q, sum_d;
  logic              ovr_q, ovr_d;

  logic              cap;
  logic              start_batch;
  logic signed [9:0] prod_ext;
  logic signed [9:0] acc_add;
  logic [3:0]        cnt_inc;
  logic [3:0]        tgt_new;

  // Q4.6 -> Q4.4 using round-half-up: add half an output LSB, then shift
  // arithmetically. The accumulator range is -512..+504, so the result
  // always fits in 8 bits and the add cannot wrap.
  function automatic logic [7:0] round_q44(input logic signed [9:0] a);
    logic signed [9:0] t;
    t = (a + 10'sd2) >>> 2;
    return t[7:0];
  endfunction

  // The block captures only on a rising edge of Done, so a Done level
  // that stays high yields a single capture.
  assign cap      = bus.Done & ~done_q;
  assign prod_ext = {{3{bus.Product[6]}}, bus.Product};
  assign acc_add  = acc_q + prod_ext;
  assign cnt_inc  = cnt_q + 4'd1;
  assign tgt_new  = (bus.Count == 3'd0) ? 4'd8 : {1'b0, bus.Count};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    sum_d       = sum_q;
    ovr_d       = ovr_q;
    start_batch = 1'b0;

    if (bus.Clr) begin
      // Clear overrides everything, including a coincident capture.
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cap) start_batch = 1'b1;
        end
        ACC: begin
          if (cap) begin
            acc_d = acc_add;
            cnt_d = cnt_inc;
            if (cnt_inc == tgt_q) begin
              state_d = FULL;
              sum_d   = round_q44(acc_add);
            end
          end
        end
        FULL: begin
          if (bus.Ready) begin
            // When the result is accepted, the same cycle can start a
            // new batch.
            if (cap) begin
              start_batch = 1'b1;
            end else begin
              state_d = IDLE;
              acc_d   = '0;
              cnt_d   = '0;
            end
          end else if (cap) begin
            // A result is still pending, so the block drops the product
            // and records the loss.
            ovr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Count is sampled here only, so changes to it mid-batch have no
      // effect.
      if (start_batch) begin
        acc_d = prod_ext;
        cnt_d = 4'd1;
        tgt_d = tgt_new;
        if (tgt_new == 4'd1) begin
          state_d = FULL;
          sum_d   = round_q44(prod_ext);
        end else begin
          state_d = ACC;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      sum_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= bus.Done;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      sum_q   <= sum_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.Valid     = (state_q == FULL);
  assign bus.Busy      = (state_q != IDLE);
  assign bus.Ovr       = ovr_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_fraction_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fraction_accumulator
// Directed scenarios, followed by randomized batches checked against an
// integer-arithmetic model of the batch total and its rounding.
// ---------------------------------------------------------------------------
module tb_fraction_accumulator;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fraction_accumulator_if bus();

  fraction_accumulator dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int q16_to_int(input logic [6:0] p);
    return p[6] ? int'(p) - 128 : int'(p);
  endfunction

  // Batch total in units of 2^-6, reported in Q4.4 as floor((s + 2) / 4).
  function automatic logic [7:0] model_sum(input int s);
    int t;
    int f;
    t = s + 2;
    f = (t >= 0) ? t / 4 : -((-t + 3) / 4);
    return f[7:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Done rising edge carrying product p, with Done held for hold cycles.
  task automatic pulse(input logic [6:0] p, input int hold = 1);
    tick();
    bus.Product = p;
    bus.Done    = 1'b1;
    repeat (hold) tick();
    bus.Done    = 1'b0;
  endtask

  task automatic accept();
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
  endtask

  // Watchdog: no step waits on the DUT, but guard the run regardless.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int         n;
  int         s;
  int         hold;
  logic [6:0] p;
  logic [7:0] e;
  logic [7:0] held_sum;
  logic       dropped;

  initial begin
    bus.Done    = 1'b0;
    bus.Product = '0;
    bus.Count   = '0;
    bus.Clr     = 1'b0;
    bus.Ready   = 1'b0;

    // ---- reset ----
    #1 rst_n = 1'b0;
    #1;
    check("rst_sum",   bus.Sum,       8'h00);
    check("rst_valid", bus.Valid,     1'b0);
    check("rst_busy",  bus.Busy,      1'b0);
    check("rst_ovr",   bus.Ovr,       1'b0);
    check("rst_state", bus.state_dbg, 2'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // ---- two-product batch: 0x20 + 0x10 = 48 -> 0x0C ----
    bus.Count = 3'd2;
    pulse(7'h20);
    check("b2_busy_mid",  bus.Busy,  1'b1);
    check("b2_valid_mid", bus.Valid, 1'b0);
    pulse(7'h10);
    check("b2_valid", bus.Valid, 1'b1);
    check("b2_sum",   bus.Sum,   8'h0C);
    accept();
    check("b2_valid_after", bus.Valid, 1'b0);
    check("b2_busy_after",  bus.Busy,  1'b0);
    check("b2_sum_hold",    bus.Sum,   8'h0C);

    // ---- Count=0 means 8: eight times -1.0 -> -8.0 ----
    bus.Count = 3'd0;
    for (int k = 0; k < 7; k++) pulse(7'h40);
    check("b8_valid_7", bus.Valid, 1'b0);
    pulse(7'h40);
    check("b8_valid", bus.Valid, 1'b1);
    check("b8_sum",   bus.Sum,   8'h80);
    accept();

    // ---- single 2^-6 rounds to zero ----
    bus.Count = 3'd1;
    pulse(7'h01);
    check("b1_valid", bus.Valid, 1'b1);
    check("b1_sum",   bus.Sum,   8'h00);
    accept();

    // ---- Done held 5 cycles: one capture only ----
    bus.Count = 3'd1;
    pulse(7'h3F, 5);
    check("hold_valid", bus.Valid, 1'b1);
    check("hold_sum",   bus.Sum,   8'h10);
    check("hold_ovr",   bus.Ovr,   1'b0);
    repeat (3) tick();
    check("hold_busy",  bus.Busy,  1'b1);
    accept();
    check("hold_busy_after", bus.Busy, 1'b0);

    // ---- drop while full, then accept plus capture in one cycle ----
    bus.Count = 3'd1;
    pulse(7'h08);
    check("ovr_sum0", bus.Sum, 8'h02);
    pulse(7'h30);
    check("ovr_set",   bus.Ovr,   1'b1);
    check("ovr_sum",   bus.Sum,   8'h02);
    check("ovr_valid", bus.Valid, 1'b1);
    bus.Count = 3'd2;
    tick();
    bus.Ready   = 1'b1;
    bus.Done    = 1'b1;
    bus.Product = 7'h10;
    tick();
    bus.Done  = 1'b0;
    bus.Ready = 1'b0;
    check("ovr_new_valid", bus.Valid, 1'b0);
    check("ovr_new_busy",  bus.Busy,  1'b1);
    check("ovr_sticky",    bus.Ovr,   1'b1);
    pulse(7'h10);
    check("ovr_new_sum", bus.Sum, 8'h08);
    accept();
    check("ovr_sticky2", bus.Ovr, 1'b1);
    bus.Clr = 1'b1;
    tick();
    bus.Clr = 1'b0;
    check("ovr_clr",      bus.Ovr, 1'b0);
    check("clr_sum_hold", bus.Sum, 8'h08);

    // ---- async reset mid-batch, release with Done already high ----
    bus.Count = 3'd3;
    pulse(7'h20);
    check("rst_mid_busy", bus.Busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sum",   bus.Sum,   8'h00);
    check("arst_busy",  bus.Busy,  1'b0);
    check("arst_valid", bus.Valid, 1'b0);
    bus.Count   = 3'd2;
    bus.Product = 7'h04;
    bus.Done    = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    bus.Done = 1'b0;
    check("arst_cap_busy", bus.Busy, 1'b1);
    pulse(7'h04);
    check("arst_valid2", bus.Valid, 1'b1);
    check("arst_sum2",   bus.Sum,   8'h02);
    accept();

    // ---- Clr coincident with a capture in ACC ----
    bus.Count = 3'd3;
    pulse(7'h10);
    tick();
    bus.Clr     = 1'b1;
    bus.Done    = 1'b1;
    bus.Product = 7'h3F;
    tick();
    bus.Clr = 1'b0;
    check("clr_busy",  bus.Busy,  1'b0);
    check("clr_ovr",   bus.Ovr,   1'b0);
    check("clr_valid", bus.Valid, 1'b0);
    tick();
    bus.Done = 1'b0;
    check("clr_no_recap", bus.Busy, 1'b0);
    bus.Count = 3'd1;
    pulse(7'h08);
    check("clr_fresh_sum", bus.Sum, 8'h02);
    accept();

    // ---- randomized batches against the model ----
    for (int b = 0; b < 24; b++) begin
      n = $urandom_range(1, 8);
      s = 0;
      bus.Count = 3'(n % 8);
      for (int k = 0; k < n; k++) begin
        p    = 7'($urandom);
        hold = $urandom_range(1, 3);
        s   += q16_to_int(p);
        if (k == n - 1) exp_q.push_back(model_sum(s));
        pulse(p, hold);
        if (k == 0) bus.Count = 3'($urandom);
        if (k < n - 1) begin
          check("rnd_busy_mid",  bus.Busy,  1'b1);
          check("rnd_valid_mid", bus.Valid, 1'b0);
        end
        repeat ($urandom_range(0, 2)) tick();
      end
      e = exp_q.pop_front();
      check("rnd_valid", bus.Valid, 1'b1);
      check("rnd_sum",   bus.Sum,   e);
      dropped = ($urandom_range(0, 3) == 0);
      if (dropped) begin
        held_sum = e;
        pulse(7'($urandom));
        check("rnd_drop_ovr", bus.Ovr, 1'b1);
        check("rnd_drop_sum", bus.Sum, held_sum);
      end
      accept();
      check("rnd_idle_valid", bus.Valid, 1'b0);
      check("rnd_idle_busy",  bus.Busy,  1'b0);
      if (dropped) begin
        bus.Clr = 1'b1;
        tick();
        bus.Clr = 1'b0;
        check("rnd_clr_ovr", bus.Ovr, 1'b0);
      end
    end

    // ---- report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
